// File: rtl/lane_tick_scheduler.sv
// Lane movement scheduler: speed-scaled base tick, per-lane rate dividers and a
// round-robin arbiter that hands one lane shift at a time to the datapath.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no offer; pick the next pending lane from rr_ptr upward
// S_OFFER | shift_valid high, shift_lane held until shift_ready
`timescale 1ns/1ps
module lane_tick_scheduler #(
   parameter int NUM_LANES = 8,
   parameter int BASE_PERIOD = 1024,
   parameter logic [2*NUM_LANES-1:0] LANE_MULT = 16'hE4E4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [2:0]                   speed,
   input  logic                         pause,
   input  logic                         clr_overrun,
   output logic                         base_tick,
   output logic                         shift_valid,
   output logic [$clog2(NUM_LANES)-1:0] shift_lane,
   input  logic                         shift_ready,
   output logic [NUM_LANES-1:0]         overrun
);

   localparam int CW = $clog2(7*BASE_PERIOD + 1);
   localparam int LW = $clog2(NUM_LANES);

   typedef enum logic {S_IDLE, S_OFFER} state_t;

   function automatic logic [LW-1:0] wrap_add(input logic [LW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_LANES) s = s - NUM_LANES;
      return LW'(s);
   endfunction

   logic [2:0]           speed_q;
   logic [CW-1:0]        base_cnt;
   logic [CW-1:0]        period_m1;
   logic                 base_en;
   logic                 speed_chg;
   logic [1:0]           lane_cnt [NUM_LANES];
   logic [NUM_LANES-1:0] expire;
   logic [NUM_LANES-1:0] pending;
   logic [NUM_LANES-1:0] accept_vec;
   logic [NUM_LANES-1:0] ovr_set;
   state_t               state, state_n;
   logic [LW-1:0]        lane_n, rr_ptr, rr_n, pick;

   assign period_m1 = CW'(BASE_PERIOD * (8 - int'(speed)) - 1);
   assign base_en   = (speed != 3'd0) && !pause;
   assign speed_chg = (speed != speed_q);
   assign base_tick = base_en && !speed_chg && (base_cnt == period_m1);

   // A speed change restarts the period so the new rate starts from a clean phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         speed_q  <= speed;
         base_cnt <= '0;
      end else begin
         speed_q <= speed;
         if (speed_chg || base_tick) base_cnt <= '0;
         else if (base_en)           base_cnt <= base_cnt + CW'(1);
      end
   end

   always_comb begin
      expire = '0;
      for (int i = 0; i < NUM_LANES; i++)
         expire[i] = base_tick && (lane_cnt[i] == LANE_MULT[2*i +: 2]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_LANES; i++) lane_cnt[i] <= 2'd0;
      end else if (base_tick) begin
         for (int i = 0; i < NUM_LANES; i++)
            lane_cnt[i] <= expire[i] ? 2'd0 : lane_cnt[i] + 2'd1;
      end
   end

   always_comb begin
      accept_vec = '0;
      if (shift_valid && shift_ready) accept_vec[shift_lane] = 1'b1;
   end

   // Expiry on the accepted lane re-arms it without counting as an overrun.
   assign ovr_set = expire & pending & ~accept_vec;

   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '0;
         overrun <= '0;
      end else begin
         pending <= expire | (pending & ~accept_vec);
         overrun <= (clr_overrun ? '0 : overrun) | ovr_set;
      end
   end

   // Descending scan so the lowest offset from rr_ptr wins.
   always_comb begin
      pick = rr_ptr;
      for (int k = NUM_LANES - 1; k >= 0; k--) begin
         if (pending[wrap_add(rr_ptr, k)]) pick = wrap_add(rr_ptr, k);
      end
   end

   always_comb begin
      state_n = state;
      lane_n  = shift_lane;
      rr_n    = rr_ptr;
      case (state)
         S_IDLE: begin
            if (|pending) begin
               state_n = S_OFFER;
               lane_n  = pick;
            end
         end
         S_OFFER: begin
            if (shift_ready) begin
               state_n = S_IDLE;
               rr_n    = wrap_add(shift_lane, 1);
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         shift_lane <= '0;
         rr_ptr     <= '0;
      end else begin
         state      <= state_n;
         shift_lane <= lane_n;
         rr_ptr     <= rr_n;
      end
   end

   assign shift_valid = (state == S_OFFER);

endmodule

// File: doc/lane_tick_scheduler.md
# lane_tick_scheduler

Generates the movement schedule for the Frogger traffic and river lanes. A speed-scaled base tick drives per-lane rate dividers. Each expiring lane raises a pending request, and the requests are serialised by a round-robin arbiter onto a single valid/ready shift port, because the game datapath can shift only one lane row per cycle. The block sits between the speed switches and the lane-shift logic inside the game module.

## Interface
- NUM_LANES, 8: number of scheduled lanes (2..16).
- BASE_PERIOD, 1024: base-tick period in clk cycles at speed 7 (≥2).
- LANE_MULT, 16'hE4E4: packed 2 bits per lane, lane i at [2i+1:2i]; lane i advances every LANE_MULT[i]+1 base ticks.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- speed  in  3  0 = frozen; 1..7 = base period BASE_PERIOD*(8-speed) cycles.
- pause  in  1  holds base counter; no new ticks while high.
- clr_overrun  in  1  clears the overrun flags.
- base_tick  out  1  one-cycle pulse per base period.
- shift_valid  out  1  a lane shift is offered.
- shift_lane  out  $clog2(NUM_LANES)  index of the offered lane.
- shift_ready  in  1  datapath accepts the offer this cycle.
- overrun  out  NUM_LANES  sticky per-lane flag: an expiry arrived while that lane was already pending.

## Operation
- Base counter:
  - Width ≥ $clog2(7*BASE_PERIOD).
  - When enabled (speed≠0, pause=0), counts 0..P-1 with P = BASE_PERIOD*(8-speed).
  - base_tick is asserted combinationally on the cycle count==P-1; the count then wraps to 0.
  - Registered copy speed_q. If speed≠speed_q, the counter is forced to 0 at that edge and no tick fires that cycle. Lane counters are untouched.
  - When disabled, the count holds and base_tick=0.
- Lane dividers: on each base_tick, lane_cnt[i] is 2 bits.
  - If lane_cnt[i]==LANE_MULT[i]: lane_cnt[i] goes to 0 and lane i expires.
  - Otherwise lane_cnt[i] increments.
- Pending[i] next-state:
  - Set on expiry.
  - Cleared on acceptance (shift_valid & shift_ready & shift_lane==i).
  - Expiry and acceptance in the same cycle leaves pending=1, with no overrun.
  - Expiry while pending=1 and not accepted: pending stays 1 (no queueing) and overrun[i] is set.
- Overrun flags: clr_overrun clears all flags. If clr_overrun coincides with a new overrun, the set wins.
- Arbiter (states IDLE, OFFER):
  - IDLE: if any pending bit is 1, select the first pending lane searching upward from rr_ptr with wrap. Register shift_lane, set shift_valid, go to OFFER. The search uses the registered pending vector, not same-cycle expiries.
  - OFFER: shift_valid and shift_lane are held stable until shift_ready.
  - On acceptance: rr_ptr goes to (shift_lane+1) mod NUM_LANES. shift_valid drops for at least one cycle (IDLE). Maximum throughput is 1 shift per 2 cycles.
  - Pause and speed changes never withdraw an active offer.

## Timing
- Reset values:
  - base count, lane_cnt, pending, rr_ptr = 0.
  - speed_q = speed.
  - base_tick=0, shift_valid=0, shift_lane=0, overrun=0.
  - State = IDLE.
- Reset mid-offer drops shift_valid on the next cycle without handshake; the pending lane is discarded.
- Latency: expiry on base_tick cycle T → pending visible in T+1 → shift_valid=1 in T+2 (if IDLE).
- First base_tick after reset with speed=s (enabled): cycle P-1 counted from the first cycle after reset deassertion.
- Fairness: with all lanes pending continuously, every lane is granted once per NUM_LANES acceptances.

## Test plan
- Base tick: BASE_PERIOD=4, speed=7, pause=0 → base_tick every 4 cycles. Change to speed=6 → counter restarts and ticks every 8 cycles; speed=0 → no ticks.
- Lane rates: BASE_PERIOD=4, speed=7, LANE_MULT lane0=0, lane1=3, shift_ready=1 → over 64 cycles, lane0 is accepted 16 times and lane1 4 times; no overrun.
- Round-robin: force lanes 0, 2, 5 pending simultaneously with ready=1 → grants 0, 2, 5 in order, shift_valid low one cycle between. Next burst with lanes 0 and 5 after rr_ptr=6 → grants 0 then 5.
- Backpressure/overrun: shift_ready=0 with lane0 period 4 cycles → shift_valid and shift_lane stay stable; overrun[0]=1 on the second expiry; still one grant when ready rises; clr_overrun → overrun=0.
- Simultaneous accept and expiry on lane0 in the same cycle → pending stays 1, re-offered two cycles later, overrun[0]=0.
- Pause and reset: pause=1 mid-offer → offer is held until accepted and no further base_ticks. Reset asserted during OFFER → next cycle all outputs 0, and the first base_tick arrives P cycles after reset deasserts.
